// File: rtl/shift_frame_sequencer_pkg.sv
// Shared types and helpers for the shift frame sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } seq_state_e;

  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_frame_sequencer_if.sv
// Producer-side handshake plus serial line and frame strobes.
interface shift_frame_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic             ser_out;
  logic             shift_en;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_data, in_dir, in_valid, hold,
    input  in_ready, ser_out, shift_en, frame_start, frame_done, busy
  );

  modport slave (
    input  in_data, in_dir, in_valid, hold,
    output in_ready, ser_out, shift_en, frame_start, frame_done, busy
  );
endinterface

// File: rtl/shift_frame_sequencer_frame_shifter.sv
// Parallel-load bidirectional shift register with zero fill; load wins over shift.
module frame_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             dir,
  output logic             out_bit
);
  import shift_seq_pkg::*;

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift) begin
      shreg_d = (dir == DirRight) ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shreg_q <= '0;
    else        shreg_q <= shreg_d;
  end

  assign out_bit = (dir == DirRight) ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/shift_frame_sequencer.sv
// Frame sequencer: accepts words, serialises them via frame_shifter, optional inter-frame gap.
module shift_frame_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic                    clk,
  input logic                    reset,
  shift_frame_sequencer_if.slave bus
);
  import shift_seq_pkg::*;

  localparam int unsigned BitW    = cnt_width(WIDTH);
  localparam int unsigned GapW    = cnt_width(GAP_CYCLES + 1);
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  seq_state_e      state_q, state_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            dir_q, dir_d;
  logic            last_bit, shift_en, in_ready, accept, out_bit;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dir_d     = dir_q;
    last_bit  = (bit_cnt_q == BitW'(WIDTH - 1));
    shift_en  = (state_q == StShift) && !bus.hold;
    // Zero-bubble reload on the last bit is only possible without a gap.
    in_ready  = (state_q == StIdle) ||
                ((state_q == StShift) && last_bit && !bus.hold && (GAP_CYCLES == 0));
    accept    = bus.in_valid && in_ready;

    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (shift_en) begin
          if (last_bit) begin
            bit_cnt_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GapW'(GapLast)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d   = StShift;
      bit_cnt_d = '0;
      dir_d     = bus.in_dir;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      dir_q     <= DirLeft;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dir_q     <= dir_d;
    end
  end

  frame_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_data(bus.in_data),
    .shift    (shift_en),
    .dir      (dir_q),
    .out_bit  (out_bit)
  );

  assign bus.in_ready    = in_ready;
  assign bus.shift_en    = shift_en;
  assign bus.ser_out     = (state_q == StShift) && out_bit;
  assign bus.frame_start = shift_en && (bit_cnt_q == '0);
  assign bus.frame_done  = shift_en && last_bit;
  assign bus.busy        = (state_q != StIdle);

endmodule
